// File: rtl/serdes_pkg.sv
// serdes_pkg -- shared definitions for the serializer/deserializer blocks.
//   DEFAULT_WIDTH : default parallel word width for bit_serializer
//   ser_state_e   : serializer FSM states (IDLE, SHIFT)
package serdes_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage : serdes_pkg

// File: rtl/bit_serializer.sv
// bit_serializer -- parallel-to-serial converter, MSB first, with a one-entry
// holding register so consecutive words stream with no bubble cycles.
//
// Ports
//   clk_i         : clock, all state changes on rising edge
//   rst_i         : asynchronous active-high reset
//   flush_i       : synchronous clear of shifter, holding register, counter, FSM
//   word_i        : parallel word (WIDTH bits)
//   word_valid_i  : word_i offered
//   word_ready_o  : word accepted this cycle if word_valid_i (holding empty, no flush)
//   data_o        : serial bit (0 whenever valid_o is 0)
//   valid_o       : data_o valid
//   busy_o        : shifting or holding register occupied
//   word_count_o  : (BIT_SERIALIZER_STATUS_EN only) saturating count of fully
//                   transmitted words, cleared by rst_i and flush_i
//
// Optional feature macro: BIT_SERIALIZER_STATUS_EN
module bit_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             word_valid_i,
    output logic             word_ready_o,
    output logic             data_o,
    output logic             valid_o,
`ifdef BIT_SERIALIZER_STATUS_EN
    output logic [15:0]      word_count_o,
`endif
    output logic             busy_o
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic [CW-1:0]    cnt_q;

    logic accept;
    logic last_bit;
    logic load_hold;   // held word -> shifter
    logic load_word;   // word_i    -> shifter directly
    logic park;        // word_i    -> holding register

    assign word_ready_o = ~hold_full_q & ~flush_i;
    assign accept       = word_valid_i & word_ready_o;
    assign last_bit     = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    assign valid_o = (state_q == SHIFT);
    assign data_o  = valid_o & shreg_q[WIDTH-1];
    assign busy_o  = (state_q == SHIFT) | hold_full_q;

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and datapath steering
    always_comb begin
        state_d   = state_q;
        load_hold = 1'b0;
        load_word = 1'b0;
        park      = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load_hold = 1'b1;
                    state_d   = SHIFT;
                end else if (accept) begin
                    load_word = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    // Refill on the edge that ends the last bit: held word
                    // first, otherwise a word accepted on this very edge.
                    if (hold_full_q)  load_hold = 1'b1;
                    else if (accept)  load_word = 1'b1;
                    else              state_d   = IDLE;
                end else if (accept) begin
                    park = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d   = IDLE;
            load_hold = 1'b0;
            load_word = 1'b0;
            park      = 1'b0;
        end
    end

    // Shifter, bit counter and holding register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (flush_i) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (load_hold) begin
                shreg_q <= hold_q;
                cnt_q   <= '0;
            end else if (load_word) begin
                shreg_q <= word_i;
                cnt_q   <= '0;
            end else if (last_bit) begin
                // Word done with nothing queued: park the counter at 0
                // rather than letting it run past WIDTH-1.
                shreg_q <= '0;
                cnt_q   <= '0;
            end else if (state_q == SHIFT) begin
                shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                cnt_q   <= cnt_q + 1'b1;
            end

            if (load_hold) hold_full_q <= 1'b0;
            if (park) begin
                hold_q      <= word_i;
                hold_full_q <= 1'b1;
            end
        end
    end

`ifdef BIT_SERIALIZER_STATUS_EN
    logic [15:0] word_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                 word_cnt_q <= '0;
        else if (flush_i)                          word_cnt_q <= '0;
        else if (last_bit && word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
    end

    assign word_count_o = word_cnt_q;
`endif

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer -- directed self-checking bench for bit_serializer (WIDTH=8).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_bit_serializer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic [7:0] word_i;
    logic       word_valid_i;
    logic       word_ready_o;
    logic       data_o;
    logic       valid_o;
    logic       busy_o;
`ifdef BIT_SERIALIZER_STATUS_EN
    logic [15:0] word_count_o;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk_i = ~clk_i;

    bit_serializer #(.WIDTH(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
`ifdef BIT_SERIALIZER_STATUS_EN
        .word_count_o (word_count_o),
`endif
        .busy_o       (busy_o)
    );

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Send a word from idle and let it drain completely.
    task automatic send_word(input logic [7:0] w);
        word_i       = w;
        word_valid_i = 1'b1;
        cycle();
        word_valid_i = 1'b0;
        repeat (9) cycle();
    endtask

    task automatic test_reset();
        // Load 0xFF into the shifter and 0x81 into the holding register,
        // then pulse reset between edges.
        word_i = 8'hFF; word_valid_i = 1'b1;
        cycle();
        word_i = 8'h81;
        cycle();
        word_valid_i = 1'b0;
        cycle();
        #2;
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({valid_o, data_o, busy_o, word_ready_o} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_async: {valid,data,busy,ready}=%b expected 0001",
                     {valid_o, data_o, busy_o, word_ready_o});
        end
        #3;
        rst_i = 1'b0;
        cycle();
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (valid_o || data_o || busy_o) seen++;
                cycle();
            end
            vectors++;
            if (seen !== 0) begin
                errors++;
                $display("FAIL reset_residual: %0d active cycles after reset, expected 0", seen);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] bits;
        logic [7:0] vld;
        int         hits;
        vectors++;
        if ({valid_o, word_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL single_pre: {valid,ready}=%b expected 01", {valid_o, word_ready_o});
        end
        word_i = 8'hDB; word_valid_i = 1'b1;
        cycle();
        word_valid_i = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bits[i] = data_o;
            vld[i]  = valid_o;
            cycle();
        end
        vectors++;
        if (vld !== 8'hFF) begin
            errors++;
            $display("FAIL single_valid: valid pattern=%b expected 11111111", vld);
        end
        vectors++;
        if (bits !== 8'hDB) begin
            errors++;
            $display("FAIL single_bits: bits=%b expected 11011011", bits);
        end
        hits = 0;
        for (int s = 0; s <= 2; s++) begin
            logic [5:0] win;
            win = bits[7-s -: 6];
            if (win == 6'b110110) hits++;
        end
        vectors++;
        if (hits !== 1) begin
            errors++;
            $display("FAIL single_detect: detector fired %0d times expected 1", hits);
        end
        vectors++;
        if ({valid_o, data_o, busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL single_post: {valid,data,busy}=%b expected 000", {valid_o, data_o, busy_o});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        logic [15:0] vld;
        logic [15:0] rdy;
        word_i = 8'hF0; word_valid_i = 1'b1;
        cycle();
        word_i = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            bits[15-i] = data_o;
            vld[15-i]  = valid_o;
            rdy[15-i]  = word_ready_o;
            cycle();
            if (i == 0) word_valid_i = 1'b0;
        end
        vectors++;
        if (vld !== 16'hFFFF) begin
            errors++;
            $display("FAIL b2b_valid: valid=%b expected all ones", vld);
        end
        vectors++;
        if (bits !== 16'hF00F) begin
            errors++;
            $display("FAIL b2b_bits: bits=%b expected 1111000000001111", bits);
        end
        // ready low for samples 1..7 (second word held until first word's last bit)
        vectors++;
        if (rdy !== 16'b1000_0000_1111_1111) begin
            errors++;
            $display("FAIL b2b_ready: ready=%b expected 1000000011111111", rdy);
        end
        vectors++;
        if ({valid_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_post: {valid,busy}=%b expected 00", {valid_o, busy_o});
        end
    endtask

    task automatic test_flush();
        int seen;
        word_i = 8'hAA; word_valid_i = 1'b1;
        cycle();
        word_i = 8'h55;
        cycle();
        word_valid_i = 1'b0;
        cycle();
        cycle();
        // now presenting the 4th bit of 0xAA with 0x55 held
        vectors++;
        if ({valid_o, busy_o, word_ready_o} !== 3'b110) begin
            errors++;
            $display("FAIL flush_pre: {valid,busy,ready}=%b expected 110", {valid_o, busy_o, word_ready_o});
        end
        flush_i = 1'b1;
        #1;
        vectors++;
        if (word_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready_comb: ready=%b expected 0", word_ready_o);
        end
        cycle();
        flush_i = 1'b0;
        #1;
        vectors++;
        if ({valid_o, data_o, busy_o, word_ready_o} !== 4'b0001) begin
            errors++;
            $display("FAIL flush_post: {valid,data,busy,ready}=%b expected 0001",
                     {valid_o, data_o, busy_o, word_ready_o});
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (valid_o || data_o) seen++;
            cycle();
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_residual: %0d output cycles after flush, expected 0", seen);
        end
    endtask

    task automatic test_collision();
        int seen;
        flush_i = 1'b1; word_i = 8'hFF; word_valid_i = 1'b1;
        #1;
        vectors++;
        if (word_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL collision_ready: ready=%b expected 0", word_ready_o);
        end
        cycle();
        flush_i = 1'b0; word_valid_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid_o || data_o || busy_o) seen++;
            cycle();
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL collision_output: %0d active cycles, expected 0", seen);
        end
    endtask

`ifdef BIT_SERIALIZER_STATUS_EN
    task automatic test_status();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        vectors++;
        if (word_count_o !== 16'd0) begin
            errors++;
            $display("FAIL status_clear0: count=%0d expected 0", word_count_o);
        end
        send_word(8'h12);
        send_word(8'h34);
        send_word(8'h56);
        vectors++;
        if (word_count_o !== 16'd3) begin
            errors++;
            $display("FAIL status_count: count=%0d expected 3", word_count_o);
        end
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        vectors++;
        if (word_count_o !== 16'd0) begin
            errors++;
            $display("FAIL status_flush: count=%0d expected 0", word_count_o);
        end
    endtask
`endif

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; word_i = '0; word_valid_i = 1'b0;
        #1;
        vectors++;
        if ({valid_o, data_o, busy_o, word_ready_o} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_initial: {valid,data,busy,ready}=%b expected 0001",
                     {valid_o, data_o, busy_o, word_ready_o});
        end
        repeat (2) cycle();
        rst_i = 1'b0;
        cycle();
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_collision();
`ifdef BIT_SERIALIZER_STATUS_EN
        test_status();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_bit_serializer
